// File: rtl/fsm_egreso.sv
// Exit-lane controller for a parking lot. It detects completed exits from two
// lane sensors and keeps a saturating vehicle count with full/empty flags.
module fsm_egreso #(
    parameter int unsigned CAPACIDAD = 15,
    parameter int unsigned W         = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         entra,
    input  logic         sale,
    input  logic         tick_entra,
    output logic         tick_sale,
    output logic [W-1:0] ocupacion,
    output logic         lleno,
    output logic         vacio,
    output logic         rechazo,
    output logic         error_sensor
);

    localparam logic [W-1:0] LP_CAP  = W'(CAPACIDAD);
    localparam logic [W-1:0] LP_ZERO = '0;
    localparam logic [W-1:0] LP_ONE  = W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IN_S  = 3'd1,
        CROSS = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    logic         r_e1, r_e2, r_s1, r_s2;
    logic [1:0]   w_es;
    state_t       r_state;
    state_t       w_next;
    logic         r_tick_sale;
    logic         r_error;
    logic [W-1:0] r_ocupacion;
    logic         r_rechazo;

    // Two-flop synchronizers for the asynchronous lane sensors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e1 <= 1'b0;
            r_e2 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_e1 <= entra;
            r_e2 <= r_e1;
            r_s1 <= sale;
            r_s2 <= r_s1;
        end
    end

    assign w_es = {r_e2, r_s2};

    // Exit sequence: inner sensor only, then outer only, then both clear
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                case (w_es)
                    2'b01:   w_next = IN_S;
                    2'b11:   w_next = ERR;
                    default: w_next = IDLE;
                endcase
            end
            IN_S: begin
                case (w_es)
                    2'b00:   w_next = IDLE;
                    2'b01:   w_next = IN_S;
                    2'b10:   w_next = CROSS;
                    default: w_next = ERR;
                endcase
            end
            CROSS: begin
                case (w_es)
                    2'b00:   w_next = DONE;
                    2'b01:   w_next = IN_S;
                    2'b10:   w_next = CROSS;
                    default: w_next = ERR;
                endcase
            end
            DONE: begin
                case (w_es)
                    2'b01:   w_next = IN_S;
                    2'b11:   w_next = ERR;
                    default: w_next = IDLE;
                endcase
            end
            ERR: begin
                if (w_es == 2'b00) w_next = IDLE;
                else               w_next = ERR;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register with state-decoded outputs registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick_sale <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_tick_sale <= (w_next == DONE);
            r_error     <= (w_next == ERR);
        end
    end

    // Saturating occupancy; a simultaneous entry and exit cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ocupacion <= LP_ZERO;
            r_rechazo   <= 1'b0;
        end else begin
            r_rechazo <= 1'b0;
            case ({tick_entra, r_tick_sale})
                2'b10: begin
                    if (r_ocupacion == LP_CAP) r_rechazo   <= 1'b1;
                    else                       r_ocupacion <= r_ocupacion + LP_ONE;
                end
                2'b01: begin
                    if (r_ocupacion == LP_ZERO) r_rechazo   <= 1'b1;
                    else                        r_ocupacion <= r_ocupacion - LP_ONE;
                end
                default: r_ocupacion <= r_ocupacion;
            endcase
        end
    end

    assign tick_sale    = r_tick_sale;
    assign error_sensor = r_error;
    assign ocupacion    = r_ocupacion;
    assign rechazo      = r_rechazo;
    assign lleno        = (r_ocupacion == LP_CAP);
    assign vacio        = (r_ocupacion == LP_ZERO);

endmodule

// File: tb/tb_fsm_egreso.sv
// Directed self-checking bench for fsm_egreso: exit sequences, aborts,
// sensor error, saturation and reset behaviour.
module tb_fsm_egreso;

    logic       clk;
    logic       reset;
    logic       entra;
    logic       sale;
    logic       tick_entra;
    logic       tick_sale;
    logic [3:0] ocupacion;
    logic       lleno;
    logic       vacio;
    logic       rechazo;
    logic       error_sensor;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tick   = 0;
    int n_rej    = 0;
    int t0;
    int r0;

    fsm_egreso #(.CAPACIDAD(15), .W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .entra        (entra),
        .sale         (sale),
        .tick_entra   (tick_entra),
        .tick_sale    (tick_sale),
        .ocupacion    (ocupacion),
        .lleno        (lleno),
        .vacio        (vacio),
        .rechazo      (rechazo),
        .error_sensor (error_sensor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (tick_sale === 1'b1) n_tick <= n_tick + 1;
        if (rechazo   === 1'b1) n_rej  <= n_rej + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pins(input logic e, input logic s, input int n);
        entra = e;
        sale  = s;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; entra = 1'b0; sale = 1'b0; tick_entra = 1'b0;
        step(); step();
        reset = 1'b0;

        chk("rst_ocupacion", 32'(ocupacion), 32'd0);
        chk("rst_vacio",     32'(vacio),     32'd1);
        chk("rst_lleno",     32'(lleno),     32'd0);
        chk("rst_tick_sale", 32'(tick_sale), 32'd0);
        chk("rst_rechazo",   32'(rechazo),   32'd0);
        chk("rst_error",     32'(error_sensor), 32'd0);

        // Reset overrides a same-cycle entry tick
        reset = 1'b1; tick_entra = 1'b1;
        step();
        reset = 1'b0; tick_entra = 1'b0;
        chk("rst_over_tick", 32'(ocupacion), 32'd0);
        step();
        chk("rst_over_tick2", 32'(ocupacion), 32'd0);

        // Three entries then a full exit sequence
        tick_entra = 1'b1;
        repeat (3) step();
        tick_entra = 1'b0;
        chk("entry3_occ",   32'(ocupacion), 32'd3);
        chk("entry3_vacio", 32'(vacio),     32'd0);
        t0 = n_tick;
        pins(1'b0, 1'b1, 4);
        pins(1'b1, 1'b0, 4);
        pins(1'b0, 1'b0, 2);
        chk("exit_edge2_tick", 32'(tick_sale), 32'd0);
        step();
        chk("exit_edge3_tick", 32'(tick_sale), 32'd1);
        chk("exit_edge3_occ",  32'(ocupacion), 32'd3);
        step();
        chk("exit_edge4_tick", 32'(tick_sale), 32'd0);
        chk("exit_edge4_occ",  32'(ocupacion), 32'd2);
        repeat (3) step();
        chk("exit_one_tick", 32'(n_tick - t0), 32'd1);

        // Back-out and reversal produce no exit
        t0 = n_tick;
        pins(1'b0, 1'b1, 4);
        pins(1'b0, 1'b0, 6);
        pins(1'b0, 1'b1, 4);
        pins(1'b1, 1'b0, 4);
        pins(1'b0, 1'b1, 4);
        pins(1'b0, 1'b0, 6);
        chk("abort_no_tick", 32'(n_tick - t0), 32'd0);
        chk("abort_occ",     32'(ocupacion),   32'd2);

        // Both sensors active: error latency, hold, recovery
        t0 = n_tick;
        pins(1'b1, 1'b1, 2);
        chk("err_edge2", 32'(error_sensor), 32'd0);
        pins(1'b1, 1'b1, 1);
        chk("err_edge3", 32'(error_sensor), 32'd1);
        pins(1'b1, 1'b1, 2);
        pins(1'b1, 1'b0, 4);
        chk("err_hold_10", 32'(error_sensor), 32'd1);
        pins(1'b0, 1'b0, 3);
        chk("err_clear", 32'(error_sensor), 32'd0);
        pins(1'b0, 1'b0, 3);
        chk("err_no_tick", 32'(n_tick - t0), 32'd0);
        chk("err_occ",     32'(ocupacion),   32'd2);

        // Saturation at full
        do_reset();
        r0 = n_rej;
        tick_entra = 1'b1;
        repeat (15) step();
        chk("full_occ",     32'(ocupacion), 32'd15);
        chk("full_lleno",   32'(lleno),     32'd1);
        chk("full_rech_0",  32'(rechazo),   32'd0);
        step();
        chk("sat_occ",  32'(ocupacion), 32'd15);
        chk("sat_rech", 32'(rechazo),   32'd1);
        tick_entra = 1'b0;
        step();
        chk("sat_rech_end", 32'(rechazo),      32'd0);
        chk("sat_rech_cnt", 32'(n_rej - r0),   32'd1);

        // Exit while empty
        do_reset();
        r0 = n_rej;
        pins(1'b0, 1'b1, 4);
        pins(1'b1, 1'b0, 4);
        pins(1'b0, 1'b0, 3);
        chk("empty_exit_tick", 32'(tick_sale), 32'd1);
        step();
        chk("empty_exit_occ",  32'(ocupacion), 32'd0);
        chk("empty_exit_rech", 32'(rechazo),   32'd1);
        chk("empty_exit_vacio", 32'(vacio),    32'd1);
        step();
        chk("empty_rech_cnt", 32'(n_rej - r0), 32'd1);

        // Simultaneous entry and exit at full
        do_reset();
        tick_entra = 1'b1;
        repeat (15) step();
        tick_entra = 1'b0;
        chk("sim15_pre", 32'(ocupacion), 32'd15);
        r0 = n_rej;
        pins(1'b0, 1'b1, 4);
        pins(1'b1, 1'b0, 4);
        pins(1'b0, 1'b0, 3);
        chk("sim15_tick", 32'(tick_sale), 32'd1);
        tick_entra = 1'b1;
        step();
        tick_entra = 1'b0;
        chk("sim15_occ",  32'(ocupacion), 32'd15);
        chk("sim15_rech", 32'(rechazo),   32'd0);
        step();
        chk("sim15_rech_cnt", 32'(n_rej - r0), 32'd0);

        // Simultaneous entry and exit at empty
        do_reset();
        r0 = n_rej;
        pins(1'b0, 1'b1, 4);
        pins(1'b1, 1'b0, 4);
        pins(1'b0, 1'b0, 3);
        chk("sim0_tick", 32'(tick_sale), 32'd1);
        tick_entra = 1'b1;
        step();
        tick_entra = 1'b0;
        chk("sim0_occ",  32'(ocupacion), 32'd0);
        chk("sim0_rech", 32'(rechazo),   32'd0);
        step();
        chk("sim0_rech_cnt", 32'(n_rej - r0), 32'd0);

        // Reset in CROSS discards the partial exit
        do_reset();
        tick_entra = 1'b1;
        repeat (5) step();
        tick_entra = 1'b0;
        chk("cross_pre_occ", 32'(ocupacion), 32'd5);
        t0 = n_tick;
        pins(1'b0, 1'b1, 4);
        pins(1'b1, 1'b0, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("cross_rst_occ",  32'(ocupacion), 32'd0);
        chk("cross_rst_tick", 32'(tick_sale), 32'd0);
        pins(1'b0, 1'b0, 8);
        chk("cross_no_tick",  32'(n_tick - t0), 32'd0);
        chk("cross_end_occ",  32'(ocupacion),   32'd0);
        chk("cross_end_vacio", 32'(vacio),      32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
